// File: rtl/uart_fifo_core.sv
// uart_fifo_core -- buffered, parametrised UART for the SoC peripheral bus.
//
// Everything runs in the clk domain. One 16x oversampling tick (every div+1
// clocks) drives both the transmitter and the receiver. rxd is the only
// asynchronous input; it passes through a 2-FF synchroniser.
//
// Compile-time option:
//   UART_PARITY_EN  when defined, parity generation/checking and the PAR
//                   states are built in; otherwise cfg_par_en/cfg_par_odd are
//                   ignored, frames carry no parity bit and rx_par_err is 0.
//
// Ports:
//   clk, rst           system clock; asynchronous active-low reset
//   div                baud divisor, one 16x tick every div+1 clocks
//   cfg_en             block enable (0 forces both FSMs idle, txd high)
//   cfg_par_en/odd     parity enable / odd select
//   cfg_stop2          two stop bits on TX
//   tx_data, tx_wr     TX FIFO write port
//   tx_full, tx_level  TX FIFO status
//   tx_busy            frame in progress or TX FIFO not empty
//   rx_data            RX FIFO head (first-word fall-through)
//   rx_frm_err         framing-error flag of the head word
//   rx_par_err         parity-error flag of the head word
//   rx_rd              pop RX FIFO head
//   rx_empty, rx_level RX FIFO status
//   rx_ovf, err_clr    sticky RX overflow and its clear
//   irq_en_rx/tx, irq  interrupt enables and registered request
//   rxd, txd           serial lines

// Circular FIFO with pointers one bit wider than the address. The read side
// is fall-through; once empty, rdata holds the last word popped.
module uart_fifo_core_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic             drop
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level   = wptr_q - rptr_q;
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so push at full still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = empty ? hold_q : mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
                hold_q <= mem[rptr_q[AW-1:0]];
            end
        end
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              div,
    input  logic                          cfg_en,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_busy,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frm_err,
    output logic                          rx_par_err,
    input  logic                          rx_rd,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_ovf,
    input  logic                          err_clr,
    input  logic                          irq_en_rx,
    input  logic                          irq_en_tx,
    output logic                          irq,
    input  logic                          rxd,
    output logic                          txd
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    logic unused_par_cfg;
    assign unused_par_cfg = cfg_par_en ^ cfg_par_odd;
`endif

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] baud_q;
    logic             tick;

    assign tick = cfg_en && (baud_q == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q <= '0;
        end else if (!cfg_en || tick) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO and transmitter
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;
    logic                 tx_pop;
    logic                 tx_drop_unused;

    uart_fifo_core_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level),
        .drop  (tx_drop_unused)
    );

    tx_state_t            tx_state_q, tx_state_d;
    logic [3:0]           tx_tcnt_q, tx_tcnt_d;
    logic [3:0]           tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_load;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_sh_q    <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_sh_q    <= tx_sh_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // The tick counter wraps 15->0 on its own, so a bit boundary needs no
    // explicit counter clear.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_sh_d    = tx_sh_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        txd        = 1'b1;
        tx_bit_end = tick && (tx_tcnt_q == 4'd15);
        if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                tx_load = !tx_empty;
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bcnt_d  = '0;
                end
            end
            TX_DATA: begin
                txd = tx_sh_q[0];
                if (tx_bit_end) begin
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_bcnt_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_d = cfg_par_en ? TX_PAR : TX_STOP1;
`else
                        tx_state_d = TX_STOP1;
`endif
                    end else begin
                        tx_bcnt_d = tx_bcnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
                txd = tx_par_q;
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP1;
                end
            end
`endif
            TX_STOP1: begin
                if (tx_bit_end) begin
                    if (cfg_stop2) begin
                        tx_state_d = TX_STOP2;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_load    = !tx_empty;
                    end
                end
            end
            TX_STOP2: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_IDLE;
                    tx_load    = !tx_empty;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase

        // Loading straight from a stop bit gives back-to-back frames.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_tcnt_d  = '0;
            tx_state_d = TX_START;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_head) ^ cfg_par_odd;
`endif
        end

        if (!cfg_en) begin
            tx_state_d = TX_IDLE;
            tx_pop     = 1'b0;
            tx_tcnt_d  = '0;
            txd        = 1'b1;
        end
    end

    assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;

    // ------------------------------------------------------------------
    // RX synchroniser and receiver
    // ------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    rx_state_t            rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [3:0]           rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push;
    logic                 rx_frm;
    logic                 rx_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // The start bit is checked at its 8th tick and the counter is re-zeroed
    // there, so every later bit end (16 ticks on) lands mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_sh_d    = rx_sh_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        rx_frm     = 1'b0;
        rx_bit_end = tick && (rx_tcnt_q == 4'd15);
        if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (tick && (rx_tcnt_q == 4'd7)) begin
                    rx_tcnt_d  = '0;
                    rx_bcnt_d  = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_d = cfg_par_en ? RX_PAR : RX_STOP;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bcnt_d = rx_bcnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_bit_end) begin
                    rx_perr_d  = rx_s2_q ^ (^rx_sh_q) ^ cfg_par_odd;
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_push    = 1'b1;
                    rx_frm     = !rx_s2_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase

        if (!cfg_en) begin
            rx_state_d = RX_IDLE;
            rx_push    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: word stored as {frm, par, data}
    // ------------------------------------------------------------------
    logic [DATA_BITS+1:0] rx_wword;
    logic [DATA_BITS+1:0] rx_head;
    logic                 rx_full_unused;
    logic                 rx_drop;

    assign rx_wword = {rx_frm, rx_perr_q, rx_sh_q};

    uart_fifo_core_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_wword),
        .pop   (rx_rd),
        .rdata (rx_head),
        .full  (rx_full_unused),
        .empty (rx_empty),
        .level (rx_level),
        .drop  (rx_drop)
    );

    assign rx_data    = rx_head[DATA_BITS-1:0];
    assign rx_par_err = rx_head[DATA_BITS];
    assign rx_frm_err = rx_head[DATA_BITS+1];

    // ------------------------------------------------------------------
    // Sticky overflow and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (rx_drop) begin
                rx_ovf <= 1'b1;
            end else if (err_clr) begin
                rx_ovf <= 1'b0;
            end
            irq <= (irq_en_rx && !rx_empty) || (irq_en_tx && (tx_level == '0)) || rx_ovf;
        end
    end
endmodule
